niossoc_irq_ctrl: RTL
=====================

// Module: niossoc_irq_ctrl
// PURPOSE
//  Interrupt aggregator downstream of the SoC peripheral irq lines (interval timer, UART, PIO).
//  Synchronises N_IRQ request lines and latches each as edge- or level-sensitive.
//  Masks the latched requests and drives one registered irq to the Nios CPU.
//  Exposes pending, mask, mode and highest-priority ID registers on a 16-bit Avalon-MM slave.
// PARAMETERS
//  N_IRQ        8   number of request inputs, 1..15; bit 0 is highest priority
//  SYNC_STAGES  2   synchroniser flops per input: 0 means already in clk domain, else 2 or 3
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  irq_in      in   N_IRQ  request lines from peripherals
//  chipselect  in   1      Avalon slave select
//  address     in   3      register word address
//  write_n     in   1      active-low write strobe
//  writedata   in   16     write data; bits >= N_IRQ are ignored
//  readdata    out  16     registered read data
//  irq         out  1      registered aggregated interrupt to CPU
//  irq_id      out  4      registered index of highest-priority active source
// BEHAVIOUR
//  Reset: all flops clear; readdata=0, irq=0, irq_id=0, MASK=0, EDGE=0, PENDING=0.
//  Reset applied mid-operation discards all pending state immediately (asynchronous).
//  sync[i]: irq_in[i] after SYNC_STAGES flops; sync_d[i] holds sync[i] delayed one cycle.
//  rise[i] = sync[i] & ~sync_d[i].
//  PENDING[i], registered each cycle:
//   - EDGE[i]=0 (level): PENDING[i] <= sync[i]; W1C has no effect.
//   - EDGE[i]=1 (edge): set on rise[i], cleared by W1C; set wins when rise and W1C coincide.
//   - FORCE write sets any bit for one cycle, edge or level; edge bits then stay latched.
//   - Changing EDGE[i] takes effect the next cycle; a latched bit stays until cleared or level-sampled.
//  active = PENDING & MASK.
//  irq <= |active. irq_id <= lowest set index of active; 0 when active=0.
//  Latency from an irq_in edge sampled at clock 0:
//   - PENDING set at clock SYNC_STAGES+1; irq high at clock SYNC_STAGES+2.
//   - A MASK/W1C write in cycle k changes irq at clock k+2.
//  Register map; write = chipselect & ~write_n; single-cycle writes, no waitrequest:
//   0 STATUS   R    active, zero-extended
//   1 PENDING  R/W1C  raw PENDING; write-1 clears edge bits only
//   2 MASK     R/W  1 = enabled
//   3 EDGE     R/W  1 = rising-edge latched, 0 = level
//   4 ID       R    {valid(bit15), 11'b0, irq_id}; valid = |active
//   5 FORCE    W    write-1 sets PENDING bits (software trigger); reads 0
//   6,7        reads 0, writes ignored
//  Reads: readdata <= mux(address) every cycle regardless of chipselect; data valid 1 cycle after address.
//  Bits N_IRQ..15 of PENDING, MASK, EDGE and STATUS read 0.
//  Reading has no side effects: reading ID does not acknowledge the source.
// TESTING
//  1 Edge, SYNC_STAGES=2: MASK=0x0001, EDGE=0x0001, 1-cycle pulse on irq_in[0]:
//    -> irq rises 4 clocks after sampling; ID reads 0x8000.
//    -> then write PENDING=0x0001 -> irq falls 2 clocks later; ID reads 0x0000.
//  2 Level: EDGE=0, MASK=0x0008, hold irq_in[3]=1 -> PENDING=0x0008, irq=1.
//    -> write PENDING=0x0008: no change.
//    -> drop irq_in[3]: PENDING=0, irq=0, 4 clocks after drop.
//  3 Priority: EDGE=0x00FF, MASK=0x00FF, rise on irq_in[2] and irq_in[5] in the same cycle:
//    -> ID=0x8002, STATUS=0x0024; clear bit 2 -> ID=0x8005.
//  4 Collision: second rise on irq_in[1] in the same cycle as a W1C of bit 1 -> PENDING[1] stays 1, irq stays 1.
//  5 Mask/force: MASK=0, FORCE=0x0010, EDGE[4]=1 -> PENDING=0x0010, STATUS=0, irq=0.
//    -> then MASK=0x0010 -> irq=1 two clocks after the write.
//  6 Reset: assert reset_n=0 while irq=1 -> irq, readdata, irq_id and all registers read 0 immediately.
//    -> after release, held irq_in stays masked (MASK=0), irq=0.

Source files
------------

// File: rtl/niossoc_irq_ctrl_if.sv
// rtl/niossoc_irq_ctrl_if.sv - Avalon-MM register slave bundle for the interrupt aggregator
// Signals:
//   chipselect  1   slave select (master -> slave)
//   address     3   register word address (master -> slave)
//   write_n     1   active-low write strobe (master -> slave)
//   writedata   16  write data (master -> slave)
//   readdata    16  registered read data (slave -> master)
interface niossoc_irq_ctrl_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niossoc_irq_ctrl.sv
// rtl/niossoc_irq_ctrl.sv - interrupt aggregator: sync, edge/level latch, mask, priority, Avalon regs
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   irq_in    in   N_IRQ request lines from peripherals
//   bus       slave Avalon-MM register port (see niossoc_irq_ctrl_if)
//   irq       out  registered aggregated interrupt to the CPU
//   irq_id    out  registered index of the highest-priority active source
module niossoc_irq_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IRQ-1:0] irq_in,
  niossoc_irq_ctrl_if.slave bus,
  output logic             irq,
  output logic [3:0]       irq_id
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_ID      = 3'd4;

  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] sync_d_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] force_set;
  logic [N_IRQ-1:0] wdata;
  logic [3:0]       id_d;
  logic             irq_q;
  logic [3:0]       irq_id_q;
  logic [15:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  // Input synchroniser; zero stages means the lines are already clk-domain.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = irq_in;
    end else begin : g_sync
      logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= irq_in;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise         = sync & ~sync_d_q;
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[N_IRQ-1:0];
  assign unused_wdata = ^bus.writedata[15:N_IRQ];
  assign w1c          = (wr_en && bus.address == ADDR_PENDING) ? wdata : '0;
  assign force_set    = (wr_en && bus.address == 3'd5) ? wdata : '0;
  assign active       = pending_q & mask_q;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && bus.address == ADDR_MASK) mask_d = wdata;
    if (wr_en && bus.address == ADDR_EDGE) edge_d = wdata;
  end

  // Edge bits hold until cleared, and a coincident rise beats the clear so
  // no event is lost; level bits simply follow the synchronised line.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_q[i]) pending_d[i] = rise[i] | force_set[i] | (pending_q[i] & ~w1c[i]);
      else           pending_d[i] = sync[i] | force_set[i];
    end
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    id_d = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) id_d = 4'(i);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:  readdata_d = 16'(active);
      ADDR_PENDING: readdata_d = 16'(pending_q);
      ADDR_MASK:    readdata_d = 16'(mask_q);
      ADDR_EDGE:    readdata_d = 16'(edge_q);
      ADDR_ID:      readdata_d = {|active, 11'b0, id_d};
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d_q   <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
      readdata_q <= '0;
    end else begin
      sync_d_q   <= sync;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_q      <= |active;
      irq_id_q   <= id_d;
      readdata_q <= readdata_d;
    end
  end

  assign irq          = irq_q;
  assign irq_id       = irq_id_q;
  assign bus.readdata = readdata_q;

endmodule
